// File: rtl/wb_queue.sv
// ---------------------------------------------------------------------------------------------
// wb_queue -- writeback stage in front of the 32x32 register file write port.
//
// Accepts completed instructions from the memory stage over a valid/ready handshake, forms the
// final result (ALU value, PC+4, or a width/sign-formatted load) at push time, and parks it in a
// small FIFO. At most one register write drains per cycle. A combinational bypass port lets
// decode see results that are still in flight.
//
// Parameters
//   DEPTH          FIFO entries; power of two, >= 2 (pointers wrap by natural overflow)
//
// Ports
//   clock          rising-edge clock
//   reset          asynchronous, active-high; clears count and pointers (storage kept)
//   in_valid       memory stage presents an instruction
//   in_ready       queue can accept this cycle (count < DEPTH)
//   in_regwrite    instruction writes rd
//   in_rd          destination register
//   in_sel         result select: 00 ALU, 01 load, 10 PC+4, 11 treated as ALU
//   in_alu_result  ALU result; bits [1:0] double as the load byte offset
//   in_mem_rdata   aligned word read from data memory
//   in_pc          instruction PC
//   in_funct3      load width/sign code
//   wb_hold        suppresses drain this cycle
//   regwrite       register file write enable
//   write_reg      register file write address (0 when not writing)
//   write_data     register file write data (0 when not writing)
//   byp_reg        register decode wants to bypass
//   byp_hit        some queued entry targets byp_reg
//   byp_data       data of the youngest matching entry (0 on miss)
// ---------------------------------------------------------------------------------------------
module wb_queue #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_regwrite,
    input  logic [4:0]  in_rd,
    input  logic [1:0]  in_sel,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_mem_rdata,
    input  logic [31:0] in_pc,
    input  logic [2:0]  in_funct3,
    input  logic        wb_hold,
    output logic        regwrite,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data,
    input  logic [4:0]  byp_reg,
    output logic        byp_hit,
    output logic [31:0] byp_data
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    // Queue state
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic [4:0]  rd_q   [DEPTH];
    logic [31:0] data_q [DEPTH];

    logic        push_en;
    logic        pop_en;
    logic [31:0] result;

    // -----------------------------------------------------------------------------------------
    // Handshake. Ready depends only on occupancy, so a full queue never passes a new entry
    // through even when the head is draining in the same cycle.
    // -----------------------------------------------------------------------------------------
    assign in_ready = (count_q < CntW'(DEPTH));

    // Instructions that do not write, or that target x0, are accepted but never stored.
    assign push_en  = in_valid & in_ready & in_regwrite & (in_rd != 5'd0);
    assign pop_en   = (count_q != '0) & ~wb_hold;

    // -----------------------------------------------------------------------------------------
    // Result formation: everything is extended before it enters the queue so the drain and
    // bypass paths carry final register values.
    // -----------------------------------------------------------------------------------------
    logic [1:0]  load_off;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    always_comb begin
        load_off  = in_alu_result[1:0];
        load_byte = 8'h00;
        load_half = 16'h0000;
        load_data = in_mem_rdata;

        unique case (load_off)
            2'd0: load_byte = in_mem_rdata[7:0];
            2'd1: load_byte = in_mem_rdata[15:8];
            2'd2: load_byte = in_mem_rdata[23:16];
            2'd3: load_byte = in_mem_rdata[31:24];
            default: load_byte = 8'h00;
        endcase

        // Halfword picks the upper or lower half only; off[0] is ignored.
        load_half = load_off[1] ? in_mem_rdata[31:16] : in_mem_rdata[15:0];

        case (in_funct3)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_data = {24'h000000, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b101:  load_data = {16'h0000, load_half};
            default: load_data = in_mem_rdata;
        endcase
    end

    always_comb begin
        result = in_alu_result;
        case (in_sel)
            2'b01:   result = load_data;
            2'b10:   result = in_pc + 32'd4;
            default: result = in_alu_result;
        endcase
    end

    // -----------------------------------------------------------------------------------------
    // Pointer and occupancy update
    // -----------------------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_en) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        unique case ({push_en, pop_en})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; occupancy alone decides which slots are meaningful.
    always_ff @(posedge clock) begin
        if (push_en) begin
            rd_q[wr_ptr_q]   <= in_rd;
            data_q[wr_ptr_q] <= result;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Drain port: zeros whenever no write is issued.
    // -----------------------------------------------------------------------------------------
    always_comb begin
        regwrite   = pop_en;
        write_reg  = 5'd0;
        write_data = 32'd0;
        if (pop_en) begin
            write_reg  = rd_q[rd_ptr_q];
            write_data = data_q[rd_ptr_q];
        end
    end

    // -----------------------------------------------------------------------------------------
    // Bypass lookup. Walk the valid entries oldest to youngest so the last match seen is the
    // youngest. The head being drained this cycle is still visible; the entry being pushed
    // this cycle is not.
    // -----------------------------------------------------------------------------------------
    logic [PtrW-1:0] byp_idx;

    always_comb begin
        byp_hit  = 1'b0;
        byp_data = 32'd0;
        byp_idx  = '0;
        if (byp_reg != 5'd0) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                byp_idx = rd_ptr_q + PtrW'(i);
                if ((CntW'(i) < count_q) && (rd_q[byp_idx] == byp_reg)) begin
                    byp_hit  = 1'b1;
                    byp_data = data_q[byp_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_queue.sv
module tb_wb_queue;

    localparam int unsigned DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_regwrite;
    logic [4:0]  in_rd;
    logic [1:0]  in_sel;
    logic [31:0] in_alu_result;
    logic [31:0] in_mem_rdata;
    logic [31:0] in_pc;
    logic [2:0]  in_funct3;
    logic        wb_hold;
    logic        regwrite;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [4:0]  byp_reg;
    logic        byp_hit;
    logic [31:0] byp_data;

    wb_queue #(.DEPTH(DEPTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_regwrite   (in_regwrite),
        .in_rd         (in_rd),
        .in_sel        (in_sel),
        .in_alu_result (in_alu_result),
        .in_mem_rdata  (in_mem_rdata),
        .in_pc         (in_pc),
        .in_funct3     (in_funct3),
        .wb_hold       (wb_hold),
        .regwrite      (regwrite),
        .write_reg     (write_reg),
        .write_data    (write_data),
        .byp_reg       (byp_reg),
        .byp_hit       (byp_hit),
        .byp_data      (byp_data)
    );

    always #5 clock = ~clock;

    // Reference model: an ordered list of pending register writes.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t mq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Result value computed arithmetically from the load/select rules.
    function automatic logic [31:0] ref_result(input logic [1:0] sel, input logic [31:0] alu,
                                               input logic [31:0] mem, input logic [31:0] pc,
                                               input logic [2:0] f3);
        logic [31:0] off;
        logic [31:0] b;
        logic [31:0] h;
        off = alu % 4;
        b   = (mem >> (8 * off)) & 32'hFF;
        h   = (mem >> (16 * (off / 2))) & 32'hFFFF;
        if (sel == 2'b10) return pc + 32'd4;
        if (sel != 2'b01) return alu;
        case (f3)
            3'b000:  return (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'b101:  return h;
            default: return mem;
        endcase
    endfunction

    task automatic check_outputs();
        logic        e_rw;
        logic [4:0]  e_reg;
        logic [31:0] e_data;
        logic        e_hit;
        logic [31:0] e_bdata;
        e_rw    = (mq.size() != 0) && !wb_hold;
        e_reg   = e_rw ? mq[0].rd : 5'd0;
        e_data  = e_rw ? mq[0].data : 32'd0;
        e_hit   = 1'b0;
        e_bdata = 32'd0;
        if (byp_reg != 5'd0) begin
            for (int k = mq.size() - 1; k >= 0; k--) begin
                if (mq[k].rd == byp_reg) begin
                    e_hit   = 1'b1;
                    e_bdata = mq[k].data;
                    break;
                end
            end
        end
        chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        chk("regwrite", 32'(regwrite), 32'(e_rw));
        chk("write_reg", 32'(write_reg), 32'(e_reg));
        chk("write_data", write_data, e_data);
        chk("byp_hit", 32'(byp_hit), 32'(e_hit));
        chk("byp_data", byp_data, e_bdata);
    endtask

    // One clock: compare before the edge, advance the model at the edge.
    task automatic step();
        bit   rdy;
        bit   rw;
        ent_t e;
        @(negedge clock);
        check_outputs();
        @(posedge clock);
        rdy = (mq.size() < DEPTH);
        rw  = (mq.size() != 0) && !wb_hold;
        if (rw) void'(mq.pop_front());
        if (in_valid && rdy && in_regwrite && in_rd != 5'd0) begin
            e.rd   = in_rd;
            e.data = ref_result(in_sel, in_alu_result, in_mem_rdata, in_pc, in_funct3);
            mq.push_back(e);
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                         input logic [1:0] sel, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [31:0] pc, input logic [2:0] f3);
        in_valid      = v;
        in_regwrite   = rw;
        in_rd         = rd;
        in_sel        = sel;
        in_alu_result = alu;
        in_mem_rdata  = mem;
        in_pc         = pc;
        in_funct3     = f3;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 2'b00, 32'd0, 32'd0, 32'd0, 3'd0);
    endtask

    task automatic load_case(input string tag, input logic [2:0] f3, input logic [31:0] alu,
                             input logic [31:0] exp);
        drive(1'b1, 1'b1, 5'd9, 2'b01, alu, 32'h80FF7F01, 32'd0, f3);
        step();
        idle();
        #2;
        chk(tag, write_data, exp);
        step();
    endtask

    initial begin
        reset   = 1'b1;
        wb_hold = 1'b0;
        byp_reg = 5'd0;
        idle();
        #12;
        chk("rst_regwrite", 32'(regwrite), 32'd0);
        chk("rst_write_reg", 32'(write_reg), 32'd0);
        chk("rst_write_data", write_data, 32'd0);
        chk("rst_byp_hit", 32'(byp_hit), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // 1: basic ALU push and one-cycle latency
        drive(1'b1, 1'b1, 5'd5, 2'b00, 32'h1234, 32'd0, 32'd0, 3'd0);
        step();
        idle();
        #2;
        chk("t1_regwrite", 32'(regwrite), 32'd1);
        chk("t1_write_reg", 32'(write_reg), 32'd5);
        chk("t1_write_data", write_data, 32'h1234);
        step();
        #2;
        chk("t1_idle_regwrite", 32'(regwrite), 32'd0);
        step();

        // 2: load formatting
        load_case("t2_lb", 3'b000, 32'h3, 32'hFFFFFF80);
        load_case("t2_lbu", 3'b100, 32'h3, 32'h00000080);
        load_case("t2_lh", 3'b001, 32'h2, 32'hFFFF80FF);
        load_case("t2_lhu", 3'b101, 32'h0, 32'h00007F01);
        load_case("t2_lw", 3'b010, 32'h1, 32'h80FF7F01);

        // 3: PC+4 wrap, dropped x0 / no-write instructions
        drive(1'b1, 1'b1, 5'd4, 2'b10, 32'h55, 32'd0, 32'hFFFFFFFC, 3'd0);
        step();
        idle();
        #2;
        chk("t3_pc4_regwrite", 32'(regwrite), 32'd1);
        chk("t3_pc4_data", write_data, 32'h0);
        step();
        drive(1'b1, 1'b1, 5'd0, 2'b00, 32'hDEAD, 32'd0, 32'd0, 3'd0);
        step();
        drive(1'b1, 1'b0, 5'd3, 2'b00, 32'hBEEF, 32'd0, 32'd0, 3'd0);
        #2;
        chk("t3_x0_regwrite", 32'(regwrite), 32'd0);
        chk("t3_x0_ready", 32'(in_ready), 32'd1);
        step();
        idle();
        #2;
        chk("t3_nw_regwrite", 32'(regwrite), 32'd0);
        chk("t3_nw_ready", 32'(in_ready), 32'd1);
        step();

        // 4: hold backpressure, ordering, no pass-through when full
        wb_hold = 1'b1;
        drive(1'b1, 1'b1, 5'd1, 2'b00, 32'h11, 32'd0, 32'd0, 3'd0);
        step();
        drive(1'b1, 1'b1, 5'd2, 2'b00, 32'h22, 32'd0, 32'd0, 3'd0);
        step();
        drive(1'b1, 1'b1, 5'd3, 2'b00, 32'h33, 32'd0, 32'd0, 3'd0);
        #2;
        chk("t4_full_ready", 32'(in_ready), 32'd0);
        step();
        wb_hold = 1'b0;
        #2;
        chk("t4_w1_reg", 32'(write_reg), 32'd1);
        chk("t4_w1_ready", 32'(in_ready), 32'd0);
        step();
        #2;
        chk("t4_w2_reg", 32'(write_reg), 32'd2);
        chk("t4_w2_ready", 32'(in_ready), 32'd1);
        step();
        idle();
        #2;
        chk("t4_w3_reg", 32'(write_reg), 32'd3);
        chk("t4_w3_data", write_data, 32'h33);
        step();
        #2;
        chk("t4_empty", 32'(regwrite), 32'd0);
        step();

        // 5: bypass youngest match
        wb_hold = 1'b1;
        drive(1'b1, 1'b1, 5'd7, 2'b00, 32'hA, 32'd0, 32'd0, 3'd0);
        step();
        drive(1'b1, 1'b1, 5'd7, 2'b00, 32'hB, 32'd0, 32'd0, 3'd0);
        step();
        idle();
        byp_reg = 5'd7;
        #2;
        chk("t5_hit", 32'(byp_hit), 32'd1);
        chk("t5_data", byp_data, 32'hB);
        byp_reg = 5'd0;
        #1;
        chk("t5_x0_hit", 32'(byp_hit), 32'd0);
        chk("t5_x0_data", byp_data, 32'd0);
        byp_reg = 5'd6;
        #1;
        chk("t5_miss_hit", 32'(byp_hit), 32'd0);
        step();

        // 6: asynchronous reset with two entries queued
        wb_hold = 1'b0;
        byp_reg = 5'd7;
        #1;
        chk("t6_pre_regwrite", 32'(regwrite), 32'd1);
        reset = 1'b1;
        #1;
        chk("t6_rst_regwrite", 32'(regwrite), 32'd0);
        chk("t6_rst_byp_hit", 32'(byp_hit), 32'd0);
        mq.delete();
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("t6_rel_ready", 32'(in_ready), 32'd1);
        chk("t6_rel_regwrite", 32'(regwrite), 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 8),
                  5'($urandom_range(0, 7)), 2'($urandom), $urandom, $urandom, $urandom,
                  3'($urandom));
            wb_hold = ($urandom_range(0, 3) == 0);
            byp_reg = 5'($urandom_range(0, 7));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
